// File: rtl/param_sync_fifo_pkg.sv
// Shared constants, read-mode enum and width helper for the parameterised synchronous FIFO.
// Read mode: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through; the default is the registered read mode.
package param_sync_fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    STD,
    FWFT
  } read_mode_e;

  // The fill level must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  localparam read_mode_e READ_MODE = FWFT;
`else
  localparam read_mode_e READ_MODE = STD;
`endif

endpackage

// File: rtl/param_sync_fifo_if.sv
// Write/read/control bundle of param_sync_fifo; master drives requests, slave is the FIFO.
interface param_sync_fifo_if
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  logic                      i_wren;
  logic [DATA_W-1:0]         i_wrdata;
  logic                      i_rden;
  logic                      i_flush;
  logic                      i_clr_err;
  logic [DATA_W-1:0]         o_rddata;
  logic                      o_rdvalid;
  logic                      o_full;
  logic                      o_empty;
  logic                      o_alm_full;
  logic                      o_alm_empty;
  logic [count_w(DEPTH)-1:0] o_count;
  logic                      o_overflow;
  logic                      o_underflow;

  modport master (
    output i_wren, i_wrdata, i_rden, i_flush, i_clr_err,
    input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_flush, i_clr_err,
    output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one synchronous write port and one asynchronous read port.
module fifo_mem
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array is deliberately not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO: pointers, fill count, registered flags, sticky errors and read port.
// PARAM_SYNC_FIFO_FWFT_EN (via param_sync_fifo_pkg::READ_MODE) selects first-word-fall-through reads.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input logic              clk,
  input logic              reset,
  param_sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DATA_W < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH - 1 ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1 || AE_THRESH >= AF_THRESH) begin : g_bad_params
    $error("param_sync_fifo: illegal DATA_W/DEPTH/threshold combination");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q, alm_full_q, alm_empty_q;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_acc, wr_acc, mem_we, rd_pop;
  logic [DATA_W-1:0] head;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc = bus.i_rden && !empty_q;
  assign wr_acc = bus.i_wren && (!full_q || rd_acc);
  assign mem_we = wr_acc && !bus.i_flush;
  assign rd_pop = rd_acc && !bus.i_flush;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.i_wrdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    end

    // Clearing wins over a new error in the same cycle; a flush never raises one.
    if (bus.i_clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (!bus.i_flush) begin
      if (bus.i_wren && !wr_acc) ovf_d = 1'b1;
      if (bus.i_rden && empty_q) udf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      empty_q     <= (count_d == '0);
      alm_full_q  <= (count_d >= AF_C);
      alm_empty_q <= (count_d <= AE_C);
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  if (READ_MODE == STD) begin : g_std
    logic [DATA_W-1:0] rddata_q;
    logic              rdvalid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rddata_q  <= '0;
        rdvalid_q <= 1'b0;
      end else begin
        rdvalid_q <= rd_pop;
        if (rd_pop) rddata_q <= head;
      end
    end

    assign bus.o_rddata  = rddata_q;
    assign bus.o_rdvalid = rdvalid_q;
  end else begin : g_fwft
    // Keeps the last presented head so the output holds steady while empty.
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
      end else if (!empty_q) begin
        hold_q <= head;
      end
    end

    assign bus.o_rddata  = empty_q ? hold_q : head;
    assign bus.o_rdvalid = !empty_q;
  end

  assign bus.o_count     = count_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_alm_full  = alm_full_q;
  assign bus.o_alm_empty = alm_empty_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;

endmodule
